// File: rtl/usr_seq.sv
// usr_seq: command sequencer for a WIDTH-bit universal shift register.
// Accepts LOAD / SHL-N / SHR-N / ROL-N over valid/ready, drives the register's
// mode select and serial/parallel inputs for the required number of cycles,
// then pulses done for one cycle with the final value present on usr_q.
module usr_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_in,
    output logic             usr_sinl,
    output logic             usr_sinr,
    output logic             busy,
    output logic             done
);

    // Command opcodes
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    // Register mode encodings
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_UP   = 2'b01;
    localparam logic [1:0] SEL_DOWN = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [1:0]       op_r;
    logic [CNT_W:0]   rem_r;
    logic [WIDTH-1:0] data_r;
    logic             fill_r;

    logic             accept;
    logic [CNT_W:0]   eff_cnt;

    // A LOAD always takes exactly one register cycle; shifts take cmd_cnt.
    assign eff_cnt = (cmd_op == OP_LOAD) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, cmd_cnt};

    // ready is only offered in IDLE and is suppressed while reset is held
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture on handshake; remaining-cycle count decrements during RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= OP_LOAD;
            rem_r  <= '0;
            data_r <= '0;
            fill_r <= 1'b0;
        end else if (accept) begin
            op_r   <= cmd_op;
            rem_r  <= eff_cnt;
            data_r <= cmd_data;
            fill_r <= cmd_fill;
        end else if (state == S_RUN) begin
            rem_r  <= rem_r - 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (eff_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rem_r == {{CNT_W{1'b0}}, 1'b1}) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Register-facing outputs, derived only from registered state and usr_q
    always_comb begin
        usr_sel  = SEL_HOLD;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        usr_in   = data_r;
        usr_sinr = fill_r;
        // rotate feeds the outgoing MSB back into bit 0
        usr_sinl = (op_r == OP_ROL) ? usr_q[WIDTH-1] : fill_r;
        if (state == S_RUN) begin
            case (op_r)
                OP_LOAD: usr_sel = SEL_LOAD;
                OP_SHL:  usr_sel = SEL_UP;
                OP_SHR:  usr_sel = SEL_DOWN;
                OP_ROL:  usr_sel = SEL_UP;
                default: usr_sel = SEL_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq driving a behavioural 4-bit universal shift register.
module tb_usr_seq;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic [WIDTH-1:0] usr_q;
    logic [1:0]       usr_sel;
    logic [WIDTH-1:0] usr_in;
    logic             usr_sinl;
    logic             usr_sinr;
    logic             busy;
    logic             done;

    int tests  = 0;
    int failed = 0;
    int hs_cnt = 0;
    int hs_mark;

    usr_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .usr_q(usr_q), .usr_sel(usr_sel), .usr_in(usr_in),
        .usr_sinl(usr_sinl), .usr_sinr(usr_sinr),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register controlled by the sequencer, sharing its reset
    always_ff @(posedge clk) begin
        if (reset) usr_q <= '0;
        else begin
            case (usr_sel)
                2'b01:   usr_q <= {usr_q[WIDTH-2:0], usr_sinl};
                2'b10:   usr_q <= {usr_sinr, usr_q[WIDTH-1:1]};
                2'b11:   usr_q <= usr_in;
                default: usr_q <= usr_q;
            endcase
        end
    end

    // Handshake counter
    always_ff @(posedge clk) begin
        if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] cnt,
                        input logic [3:0] data, input logic fill);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = '0;
        cmd_data = '0; cmd_fill = 1'b0;
        tick(); tick();
        chk("ready_in_reset", {7'd0, cmd_ready}, 8'd0);
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_sel", {6'd0, usr_sel}, 8'd0);
        chk("rst_in", {4'd0, usr_in}, 8'd0);
        chk("rst_sin", {6'd0, usr_sinl, usr_sinr}, 8'd0);
        chk("rst_q", {4'd0, usr_q}, 8'd0);
        chk("rst_ready", {7'd0, cmd_ready}, 8'd1);

        // 1. LOAD 1011
        send(2'b00, 3'd5, 4'b1011, 1'b0);
        tick();                               // edge T
        cmd_valid = 1'b0; cmd_data = 4'b0110;
        chk("ld_sel", {6'd0, usr_sel}, 8'h3);
        chk("ld_in", {4'd0, usr_in}, 8'hB);
        chk("ld_busy_rdy", {6'd0, busy, cmd_ready}, 8'h2);
        tick();                               // T+2
        chk("ld_done", {7'd0, done}, 8'd1);
        chk("ld_q", {4'd0, usr_q}, 8'hB);
        chk("ld_sel_done", {6'd0, usr_sel}, 8'h0);
        tick();                               // T+3
        chk("ld_ready_back", {6'd0, cmd_ready, done}, 8'h2);

        // 2. SHL 2 fill 0 from 1011
        send(2'b01, 3'd2, 4'b0000, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("shl_sel1", {6'd0, usr_sel}, 8'h1);
        tick();
        chk("shl_q1", {4'd0, usr_q}, 8'h6);
        chk("shl_sel2", {6'd0, usr_sel}, 8'h1);
        tick();                               // T+3
        chk("shl_done", {7'd0, done}, 8'd1);
        chk("shl_q2", {4'd0, usr_q}, 8'hC);
        tick();

        // 3. SHR 1 fill 1, then SHR 7 fill 0
        send(2'b10, 3'd1, 4'b0000, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("shr1_sel_sinr", {5'd0, usr_sel, usr_sinr}, 8'h5);
        tick();
        chk("shr1_done_q", {3'd0, done, usr_q}, 8'h1E);
        tick();
        send(2'b10, 3'd7, 4'b0000, 1'b0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cmd_cnt = 3'(i); cmd_fill = ~cmd_fill;  // ignored while busy
            chk("shr7_run", {5'd0, usr_sel, done}, 8'h4);
            tick();
        end
        chk("shr7_done_q", {3'd0, done, usr_q}, 8'h10);
        tick();

        // 4. LOAD 1110, ROL 3, ROL 4
        send(2'b00, 3'd0, 4'b1110, 1'b0);
        tick(); cmd_valid = 1'b0; tick(); tick();
        chk("ld2_q", {4'd0, usr_q}, 8'hE);
        send(2'b11, 3'd3, 4'b1110, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("rol_sinl", {5'd0, usr_sel, usr_sinl}, 8'h3);
        tick();
        chk("rol_q1", {4'd0, usr_q}, 8'hD);
        tick();
        chk("rol_q2", {4'd0, usr_q}, 8'hB);
        tick();
        chk("rol_q3_done", {3'd0, done, usr_q}, 8'h17);
        tick();
        send(2'b11, 3'd4, 4'b1110, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("rol4_sinl0", {7'd0, usr_sinl}, 8'h0);
        tick(); tick(); tick(); tick();
        chk("rol4_done_q", {3'd0, done, usr_q}, 8'h17);
        tick();

        // 5. LOAD 1010, SHL 0, then a held command during busy
        send(2'b00, 3'd0, 4'b1010, 1'b0);
        tick(); cmd_valid = 1'b0; tick(); tick();
        hs_mark = hs_cnt;
        send(2'b01, 3'd0, 4'b0000, 1'b1);
        tick();                               // T+1 is DONE
        cmd_op = 2'b00; cmd_data = 4'b1111;   // next command, held valid
        chk("shl0_done", {4'd0, busy, done, cmd_ready, 1'b0}, 8'h0C);
        chk("shl0_sel_q", {2'd0, usr_sel, usr_q}, 8'h0A);
        chk("shl0_in", {4'd0, usr_in}, 8'h0);
        tick();                               // IDLE, ready high
        cmd_data = 4'b0101;
        chk("held_ready", {7'd0, cmd_ready}, 8'd1);
        tick();                               // accepted
        cmd_data = 4'b0011;
        chk("held_sel_in", {2'd0, usr_sel, usr_in}, 8'h35);
        cmd_valid = 1'b0;
        chk("hs_once", 8'(hs_cnt - hs_mark), 8'd2);
        tick();
        chk("held_done_q", {3'd0, done, usr_q}, 8'h15);
        tick();

        // 6. Reset during SHR 5
        send(2'b10, 3'd5, 4'b0000, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("abort_mid_q", {4'd0, usr_q}, 8'h2);
        reset = 1'b1;
        tick();
        chk("abort_state", {4'd0, busy, done, cmd_ready, 1'b0}, 8'h0);
        chk("abort_q", {4'd0, usr_q}, 8'h0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {6'd0, cmd_ready, done}, 8'h2);
        tick();
        chk("abort_no_done", {6'd0, busy, done}, 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/usr_seq.md
# usr_seq

Command sequencer for the 4-bit universal shift register (parallel load, shift toward MSB, shift toward LSB, hold). It accepts one command at a time over a valid/ready handshake: load, shift-left-N, shift-right-N or rotate-left-N. For each command it drives the register's mode select, parallel input and serial fill inputs for exactly the required number of clock cycles, then pulses `done`. It sits between a host/control FSM and the shift register instance, and shares that register's clock and reset.

## Interface
Parameters:
- `WIDTH`, 4 — width of the controlled shift register.
- `CNT_W`, 3 — width of the shift-count field (max count 2^CNT_W−1).

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high. The same net also resets the shift register.
- `cmd_valid`  in  1  — command present.
- `cmd_ready`  out  1  — sequencer can accept a command.
- `cmd_op`  in  2  — command opcode: 00 LOAD, 01 SHL, 10 SHR, 11 ROL.
- `cmd_cnt`  in  CNT_W  — shift/rotate count (ignored for LOAD).
- `cmd_data`  in  WIDTH  — parallel load value (LOAD only).
- `cmd_fill`  in  1  — serial fill bit for SHL/SHR.
- `usr_q`  in  WIDTH  — shift register parallel output.
- `usr_sel`  out  2  — register mode: 00 hold, 01 shift toward MSB (bit0 ← `usr_sinl`), 10 shift toward LSB (bit WIDTH−1 ← `usr_sinr`), 11 parallel load.
- `usr_in`  out  WIDTH  — parallel load data.
- `usr_sinl`  out  1  — serial input into bit 0.
- `usr_sinr`  out  1  — serial input into bit WIDTH−1.
- `busy`  out  1  — command in progress (state ≠ IDLE).
- `done`  out  1  — one-cycle completion pulse; `usr_q` holds the final result in this cycle.

## Operation
- Captured registers: `op_r`, `rem_r` (CNT_W+1 bits), `data_r`, and `fill_r`. They load on handshake (`cmd_valid & cmd_ready`). `rem_r` = 1 for LOAD, else `cmd_cnt`.
- States:
  - IDLE: `cmd_ready` = ~reset; `usr_sel` = 00. On handshake go to DONE if the effective count is 0, else go to RUN.
  - RUN: `usr_sel` = 11 (LOAD), 01 (SHL, ROL), 10 (SHR). `rem_r` decrements each cycle. When `rem_r` == 1, go to DONE.
  - DONE: `usr_sel` = 00, `done` = 1. Go to IDLE unconditionally.
- `usr_in` = `data_r` at all times.
- `usr_sinr` = `fill_r`.
- `usr_sinl` = `usr_q[WIDTH-1]` when `op_r` == ROL, else `fill_r`.
- Counts ≥ WIDTH are legal:
  - SHL/SHR fully replace the contents with the fill bit.
  - ROL by k·WIDTH returns the original value.
- `cmd_ready` is 0 in RUN and DONE. Commands presented then are not accepted; the master holds them per valid/ready rules.
- `cmd_*` changes while busy have no effect on the command in progress.
- Reset values (state after a reset edge):
  - state IDLE, `busy` 0, `done` 0, `usr_sel` 00.
  - `data_r` 0, `fill_r` 0, `rem_r` 0, so `usr_in` = 0 and `usr_sinl` = `usr_sinr` = 0.
  - `usr_q` = 0 via the shared reset.
- Reset asserted in RUN or DONE aborts the command: no `done` pulse, and the register clears to 0.
- `cmd_ready` is forced to 0 while `reset` is high.

## Timing
- Handshake at edge T. RUN occupies cycles T+1 … T+N, with N = effective count.
- The register updates on each edge ending a RUN cycle.
- DONE is cycle T+N+1, with `usr_q` final. `cmd_ready` returns high at T+N+2.
- Zero-count command: DONE at T+1, register unchanged.
- Total occupancy is N+2 cycles per command; back-to-back throughput is one command per N+2 cycles.
- `usr_sel`, `usr_sinl` and `busy` are combinational from registered state plus `usr_q` only. There is no path from `cmd_*` to `usr_*`.

## Test plan
Bench setting: WIDTH=4, CNT_W=3, with the sequencer driving a real shift register instance.
1. Reset, then LOAD `cmd_data`=1011 → `usr_sel`=11 for exactly 1 cycle; `done` at T+2 with `usr_q`=1011; `cmd_ready` high at T+3.
2. From 1011: SHL cnt=2 fill=0 → `usr_sel`=01 for 2 cycles, `usr_q` 0110 then 1100; `done` at T+3.
3. From 1100: SHR cnt=1 fill=1 → `usr_q`=1110 at `done`. Then SHR cnt=7 fill=0 → `usr_q`=0000, `done` at T+8.
4. LOAD 1110, then ROL cnt=3 → `usr_q` steps 1101, 1011, 0111. Then ROL cnt=4 on 0111 → `usr_q`=0111 at `done`.
5. SHL cnt=0 with register 1010 → no cycle with `usr_sel`≠00; `done` at T+1; `usr_q`=1010. Hold `cmd_valid` high through `busy` with changing `cmd_data` → only one handshake occurs, at the next IDLE.
6. Assert `reset` during RUN of SHR cnt=5 → next cycle state IDLE, `usr_q`=0000, no `done` pulse, `cmd_ready`=0 while reset is high and 1 after.
